// File: rtl/pgm_sched.sv
// pgm_sched: program packet scheduler sitting on the configuration chain.
// Every config flit is re-registered downstream with one cycle of latency.
// Header flits addressed to MODULE_ID read or write the local registers.
// A five-state FSM paces start/finish pulses toward pgm_rd, using the
// REPEAT count and the INTERVAL gap.
module pgm_sched #(
    parameter logic [7:0] MODULE_ID = 8'd63
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [133:0] cin_sched_data,
    input  logic         cin_sched_data_wr,
    output logic         cout_sched_ready,
    output logic [133:0] cout_sched_data,
    output logic         cout_sched_data_wr,
    input  logic         cin_sched_ready,
    input  logic         in_rd_alf,
    input  logic         rd2sched_pkt_done,
    output logic         pgm_bypass_flag,
    output logic         pgm_sent_start_flag,
    output logic         pgm_sent_finish_flag
);

    localparam logic [5:0]  KIND_HEADER = 6'h01;
    localparam logic [2:0]  OP_WRITE    = 3'b001;
    localparam logic [2:0]  OP_READ     = 3'b010;
    localparam logic [2:0]  OP_READ_RSP = 3'b011;
    localparam logic [7:0]  ADDR_CTRL     = 8'h01;
    localparam logic [7:0]  ADDR_REPEAT   = 8'h02;
    localparam logic [7:0]  ADDR_INTERVAL = 8'h03;
    localparam logic [7:0]  ADDR_STATUS   = 8'h04;
    localparam logic [31:0] CNT_MAX       = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_DONE,
        GAP,
        FINISH
    } state_t;

    state_t        state_reg, state_next;
    logic          enable_reg, enable_next;
    logic          bypass_reg, bypass_next;
    logic [31:0]   repeat_reg, repeat_next;
    logic [31:0]   interval_reg, interval_next;
    logic [31:0]   sent_cnt_reg, sent_cnt_next;
    logic [31:0]   gap_cnt_reg, gap_cnt_next;
    logic [133:0]  flit_reg, flit_next;
    logic          flit_wr_reg;

    // Flit field views
    logic [5:0]    flit_kind;
    logic [2:0]    flit_op;
    logic [7:0]    flit_id;
    logic [7:0]    flit_addr;
    logic [31:0]   flit_mask;
    logic [31:0]   flit_data;
    logic          cfg_hit;
    logic          cfg_wr;
    logic          cfg_rd;
    logic [31:0]   rd_value;
    logic [31:0]   ctrl_value;
    logic [31:0]   ctrl_written;
    logic [31:0]   sent_cnt_inc;
    logic          run_allowed;
    logic          pkt_done;

    assign flit_kind = cin_sched_data[133:128];
    assign flit_op   = cin_sched_data[126:124];
    assign flit_id   = cin_sched_data[103:96];
    assign flit_addr = cin_sched_data[71:64];
    assign flit_mask = cin_sched_data[63:32];
    assign flit_data = cin_sched_data[31:0];

    assign cfg_hit = cin_sched_data_wr && (flit_kind == KIND_HEADER) && (flit_id == MODULE_ID);
    assign cfg_wr  = cfg_hit && (flit_op == OP_WRITE);
    assign cfg_rd  = cfg_hit && (flit_op == OP_READ);

    assign ctrl_value   = {30'd0, bypass_reg, enable_reg};
    assign ctrl_written = (ctrl_value & ~flit_mask) | (flit_data & flit_mask);

    // Saturating increment of the sent-packet count
    assign sent_cnt_inc = (sent_cnt_reg == CNT_MAX) ? sent_cnt_reg : sent_cnt_reg + 32'd1;

    // Packets may keep flowing only while enabled and not bypassed
    assign run_allowed = enable_reg && !bypass_reg;

    // Done is meaningful only while a packet is outstanding
    assign pkt_done = (state_reg == WAIT_DONE) && rd2sched_pkt_done;

    assign cout_sched_ready     = cin_sched_ready;
    assign cout_sched_data      = flit_reg;
    assign cout_sched_data_wr   = flit_wr_reg;
    assign pgm_bypass_flag      = bypass_reg;

    // Register read mux for read-response headers
    always_comb begin
        rd_value = 32'd0;
        case (flit_addr)
            ADDR_CTRL:     rd_value = ctrl_value;
            ADDR_REPEAT:   rd_value = repeat_reg;
            ADDR_INTERVAL: rd_value = interval_reg;
            ADDR_STATUS:   rd_value = sent_cnt_reg;
            default:       rd_value = 32'd0;
        endcase
    end

    // Outgoing flit: pass through, rewriting only matching read headers
    always_comb begin
        flit_next = cin_sched_data;
        if (cfg_rd) begin
            flit_next[126:124] = OP_READ_RSP;
            flit_next[31:0]    = rd_value;
        end
    end

    // Masked config writes; the FINISH auto-clear of enable wins over a write
    always_comb begin
        enable_next   = enable_reg;
        bypass_next   = bypass_reg;
        repeat_next   = repeat_reg;
        interval_next = interval_reg;
        if (cfg_wr) begin
            case (flit_addr)
                ADDR_CTRL: begin
                    enable_next = ctrl_written[0];
                    bypass_next = ctrl_written[1];
                end
                ADDR_REPEAT:   repeat_next   = (repeat_reg & ~flit_mask) | (flit_data & flit_mask);
                ADDR_INTERVAL: interval_next = (interval_reg & ~flit_mask) | (flit_data & flit_mask);
                default: ;
            endcase
        end
        if (state_reg == FINISH) begin
            enable_next = 1'b0;
        end
    end

    // Sent counter: counts completed packets, restarts on a fresh enable
    always_comb begin
        sent_cnt_next = sent_cnt_reg;
        if (pkt_done) begin
            sent_cnt_next = sent_cnt_inc;
        end
        if (!enable_reg && enable_next) begin
            sent_cnt_next = 32'd0;
        end
    end

    // Scheduler FSM next-state and pulse outputs
    always_comb begin
        state_next           = state_reg;
        gap_cnt_next         = gap_cnt_reg;
        pgm_sent_start_flag  = 1'b0;
        pgm_sent_finish_flag = 1'b0;
        case (state_reg)
            IDLE: begin
                if (run_allowed) begin
                    state_next = START;
                end
            end
            START: begin
                if (!in_rd_alf) begin
                    pgm_sent_start_flag = 1'b1;
                    state_next          = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (pkt_done) begin
                    if ((repeat_reg != 32'd0) && (sent_cnt_inc == repeat_reg)) begin
                        state_next = FINISH;
                    end else if (!run_allowed) begin
                        state_next = FINISH;
                    end else if (interval_reg == 32'd0) begin
                        state_next = START;
                    end else begin
                        state_next   = GAP;
                        gap_cnt_next = interval_reg;
                    end
                end
            end
            GAP: begin
                if (!run_allowed) begin
                    state_next   = FINISH;
                    gap_cnt_next = 32'd0;
                end else if (gap_cnt_reg <= 32'd1) begin
                    state_next   = START;
                    gap_cnt_next = 32'd0;
                end else begin
                    gap_cnt_next = gap_cnt_reg - 32'd1;
                end
            end
            FINISH: begin
                pgm_sent_finish_flag = 1'b1;
                state_next           = IDLE;
            end
            default: begin
                state_next   = IDLE;
                gap_cnt_next = 32'd0;
            end
        endcase
    end

    // FSM state and gap counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            gap_cnt_reg <= 32'd0;
        end else begin
            state_reg   <= state_next;
            gap_cnt_reg <= gap_cnt_next;
        end
    end

    // Configuration registers and sent counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_reg   <= 1'b0;
            bypass_reg   <= 1'b0;
            repeat_reg   <= 32'd0;
            interval_reg <= 32'd0;
            sent_cnt_reg <= 32'd0;
        end else begin
            enable_reg   <= enable_next;
            bypass_reg   <= bypass_next;
            repeat_reg   <= repeat_next;
            interval_reg <= interval_next;
            sent_cnt_reg <= sent_cnt_next;
        end
    end

    // One-cycle registered config chain output; reset drops any flit in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flit_reg    <= '0;
            flit_wr_reg <= 1'b0;
        end else begin
            flit_reg    <= flit_next;
            flit_wr_reg <= cin_sched_data_wr;
        end
    end

endmodule

// File: tb/tb_pgm_sched.sv
// Directed bench for pgm_sched: config chain scoreboard plus FSM pulse timing.
module tb_pgm_sched;

    localparam logic [7:0] ID  = 8'd63;
    localparam logic [5:0] HDR = 6'h01;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [133:0] cin_data;
    logic         cin_wr;
    logic         cout_ready;
    logic [133:0] cout_data;
    logic         cout_wr;
    logic         cin_ready;
    logic         alf;
    logic         done;
    logic         bypass;
    logic         start;
    logic         finish;

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;
    int start_log[$];
    int finish_log[$];
    logic [133:0] exp_q[$];
    int done_dly = 0;
    int done_at  = -1;
    int seen     = 0;

    pgm_sched #(.MODULE_ID(ID)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .cin_sched_data       (cin_data),
        .cin_sched_data_wr    (cin_wr),
        .cout_sched_ready     (cout_ready),
        .cout_sched_data      (cout_data),
        .cout_sched_data_wr   (cout_wr),
        .cin_sched_ready      (cin_ready),
        .in_rd_alf            (alf),
        .rd2sched_pkt_done    (done),
        .pgm_bypass_flag      (bypass),
        .pgm_sent_start_flag  (start),
        .pgm_sent_finish_flag (finish)
    );

    always #5 clk = ~clk;

    // Log the cycle of every start/finish pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (start === 1'b1) start_log.push_back(cyc);
        if (finish === 1'b1) finish_log.push_back(cyc);
    end

    task automatic check(input string tag, input logic [133:0] obs, input logic [133:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        check(tag, 134'(obs), 134'(exp));
    endtask

    function automatic int at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic logic [133:0] mk(input logic [5:0] kind, input logic [2:0] op,
                                        input logic [7:0] id, input logic [7:0] addr,
                                        input logic [31:0] mask, input logic [31:0] data);
        logic [133:0] f;
        f = '0;
        f[133:128] = kind;
        f[127]     = 1'b1;
        f[126:124] = op;
        f[123:104] = 20'hC0FFE;
        f[103:96]  = id;
        f[95:72]   = 24'hA5A5A5;
        f[71:64]   = addr;
        f[63:32]   = mask;
        f[31:0]    = data;
        return f;
    endfunction

    // Advance to just after the next rising edge; model pgm_rd's done reply
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (start_log.size() > seen) begin
            seen = start_log.size();
            if (done_dly > 0) done_at = start_log[seen-1] + done_dly;
        end
        done = (cyc == done_at);
    endtask

    // Drive one flit, push its expected image, pop and compare one cycle later
    task automatic send(input logic [133:0] f, input logic [133:0] e);
        logic [133:0] got;
        tick();
        cin_data = f;
        cin_wr   = 1'b1;
        exp_q.push_back(e);
        tick();
        cin_wr   = 1'b0;
        cin_data = '0;
        @(negedge clk);
        check("cout_wr_latency", 134'(cout_wr), 134'(1'b1));
        if (cout_wr === 1'b1 && exp_q.size() > 0) begin
            got = cout_data;
            check("cout_data", got, exp_q.pop_front());
        end
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] mask, input logic [31:0] data);
        logic [133:0] f;
        f = mk(HDR, 3'b001, ID, addr, mask, data);
        send(f, f);
    endtask

    task automatic rd(input logic [7:0] addr, input logic [31:0] expv);
        send(mk(HDR, 3'b010, ID, addr, 32'h0, 32'hDEADBEEF),
             mk(HDR, 3'b011, ID, addr, 32'h0, expv));
    endtask

    initial begin
        logic [133:0] f;
        int sb, fb, a;
        rst_n = 1'b0; cin_ready = 1'b1; cin_data = '0; cin_wr = 1'b0;
        alf = 1'b0; done = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_start", 134'(start), 134'(1'b0));
        check("rst_finish", 134'(finish), 134'(1'b0));
        check("rst_bypass", 134'(bypass), 134'(1'b0));
        check("rst_cout_wr", 134'(cout_wr), 134'(1'b0));
        check("rst_cout_data", cout_data, '0);
        check("rst_ready_hi", 134'(cout_ready), 134'(1'b1));
        cin_ready = 1'b0;
        #1;
        check("rst_ready_lo", 134'(cout_ready), 134'(1'b0));
        cin_ready = 1'b1;
        rst_n = 1'b1;
        tick();

        // Config path: foreign ID and body flits pass through untouched
        f = mk(HDR, 3'b001, 8'd62, 8'h01, 32'hFFFFFFFF, 32'h1);
        send(f, f);
        f = mk(6'h03, 3'b001, ID, 8'h01, 32'hFFFFFFFF, 32'h1);
        send(f, f);
        f = mk(HDR, 3'b010, 8'd62, 8'h04, 32'h0, 32'h12345678);
        send(f, f);
        rd(8'h01, 32'h0);
        wr(8'h03, 32'hFFFFFFFF, 32'h12345678);
        wr(8'h03, 32'h0000FFFF, 32'hAAAABBBB);
        rd(8'h03, 32'h1234BBBB);
        rd(8'h07, 32'h0);
        wr(8'h04, 32'hFFFFFFFF, 32'h55);
        rd(8'h04, 32'h0);

        // Bounded run: two packets, gap of 3, done 5 cycles after each start
        wr(8'h02, 32'hFFFFFFFF, 32'd2);
        wr(8'h03, 32'hFFFFFFFF, 32'd3);
        sb = start_log.size(); fb = finish_log.size();
        done_dly = 5;
        wr(8'h01, 32'hFFFFFFFF, 32'h1);
        repeat (40) tick();
        checki("run_start_count", start_log.size() - sb, 2);
        checki("run_finish_count", finish_log.size() - fb, 1);
        checki("run_restart_after_done", at(start_log, sb + 1) - (at(start_log, sb) + 5), 4);
        checki("run_finish_after_done", at(finish_log, fb) - (at(start_log, sb + 1) + 5), 1);
        rd(8'h04, 32'd2);
        rd(8'h01, 32'h0);

        // Backpressure: alf holds START; enabling again restarts the count
        alf = 1'b1;
        wr(8'h02, 32'hFFFFFFFF, 32'd1);
        sb = start_log.size(); fb = finish_log.size();
        done_dly = 3;
        wr(8'h01, 32'h00000001, 32'h1);
        repeat (10) tick();
        checki("bp_no_start", start_log.size() - sb, 0);
        tick();
        alf = 1'b0;
        a = cyc;
        repeat (10) tick();
        checki("bp_start_cycle", at(start_log, sb), a);
        checki("bp_finish_cycle", at(finish_log, fb), a + 4);
        rd(8'h04, 32'd1);

        // Reset in the middle of a continuous run
        wr(8'h02, 32'hFFFFFFFF, 32'd0);
        sb = start_log.size(); fb = finish_log.size();
        done_dly = 5;
        wr(8'h01, 32'h00000001, 32'h1);
        repeat (10) tick();
        rd(8'h04, 32'd1);
        tick();
        done_dly = 0;
        cin_data = mk(HDR, 3'b001, 8'd62, 8'h01, 32'hFFFFFFFF, 32'h1);
        cin_wr = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_start", 134'(start), 134'(1'b0));
        check("mid_rst_finish", 134'(finish), 134'(1'b0));
        check("mid_rst_bypass", 134'(bypass), 134'(1'b0));
        check("mid_rst_cout_wr", 134'(cout_wr), 134'(1'b0));
        tick();
        cin_wr = 1'b0;
        cin_data = '0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_cout_wr", 134'(cout_wr), 134'(1'b0));
        repeat (15) tick();
        checki("rst_start_count", start_log.size() - sb, 2);
        checki("rst_no_finish", finish_log.size() - fb, 0);
        rd(8'h04, 32'd0);
        rd(8'h01, 32'h0);

        // Early disable while a packet is outstanding
        sb = start_log.size(); fb = finish_log.size();
        done_dly = 8;
        wr(8'h01, 32'h00000001, 32'h1);
        repeat (3) tick();
        wr(8'h01, 32'h00000001, 32'h0);
        repeat (20) tick();
        checki("dis_start_count", start_log.size() - sb, 1);
        checki("dis_finish_count", finish_log.size() - fb, 1);
        checki("dis_finish_cycle", at(finish_log, fb), at(start_log, sb) + 9);

        // Bypass: flag follows CTRL.bypass and no packet is started
        sb = start_log.size();
        done_dly = 0;
        wr(8'h01, 32'h00000003, 32'h3);
        check("byp_flag_on", 134'(bypass), 134'(1'b1));
        repeat (10) tick();
        checki("byp_no_start", start_log.size() - sb, 0);
        rd(8'h01, 32'h3);
        wr(8'h01, 32'h00000003, 32'h0);
        check("byp_flag_off", 134'(bypass), 134'(1'b0));

        checki("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pgm_sched.md
PGM_SCHED -- requirements
Module: pgm_sched

Interface
REQ-001 SHALL have parameter MODULE_ID, default 8'd63, the config-chain module ID this block answers to.
REQ-002 SHALL have port clk, input, 1 bit, the single clock.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port cin_sched_data, input, 134 bits, config flit from the upstream chain.
REQ-005 SHALL have port cin_sched_data_wr, input, 1 bit, config flit valid.
REQ-006 SHALL have port cout_sched_ready, output, 1 bit, ready to upstream.
REQ-007 SHALL have port cout_sched_data, output, 134 bits, config flit to the downstream chain.
REQ-008 SHALL have port cout_sched_data_wr, output, 1 bit, downstream flit valid.
REQ-009 SHALL have port cin_sched_ready, input, 1 bit, ready from downstream.
REQ-010 SHALL have port in_rd_alf, input, 1 bit, pgm_rd almost-full, which blocks a start.
REQ-011 SHALL have port rd2sched_pkt_done, input, 1 bit, a one-cycle pulse when pgm_rd finishes one program packet.
REQ-012 SHALL have port pgm_bypass_flag, output, 1 bit, bypass level to pgm_rd.
REQ-013 SHALL have port pgm_sent_start_flag, output, 1 bit, one-cycle start pulse to pgm_rd.
REQ-014 SHALL have port pgm_sent_finish_flag, output, 1 bit, one-cycle finish pulse to pgm_rd.

Function
REQ-015 SHALL decode the config flit as follows:
- [133:128]: 01 = header, 10 = tail, 11 = body.
- [126:124]: opcode, 001 = write, 010 = read, 011 = read response.
- [103:96]: target module ID.
- [71:64]: register address.
- [63:32]: mask.
- [31:0]: data.
REQ-016 SHALL act only on header flits with cin_sched_data_wr=1 and [103:96]==MODULE_ID; all other flits pass through unchanged.
REQ-017 SHALL implement these registers:
- 0x01 CTRL: bit0 enable, bit1 bypass.
- 0x02 REPEAT: 32 bits, 0 = continuous.
- 0x03 INTERVAL: 32-bit gap in cycles.
- 0x04 STATUS: read-only sent count.
REQ-018 SHALL apply a write as reg = (reg & ~mask) | (data & mask); writes to 0x04 or an unknown address are ignored.
REQ-019 SHALL register every flit to cout_sched_data/cout_sched_data_wr with exactly 1-cycle latency.
REQ-020 SHALL, for a matching read header, forward it with [126:124]=011 and [31:0]=the register value (0 for an unknown address), all other bits unchanged.
REQ-021 SHALL drive cout_sched_ready = cin_sched_ready combinationally.
REQ-022 SHALL drive pgm_bypass_flag from the CTRL.bypass register bit.
REQ-023 SHALL implement FSM states IDLE, START, WAIT_DONE, GAP and FINISH.
REQ-024 SHALL move IDLE -> START when enable=1 and bypass=0.
REQ-025 SHALL, in START with in_rd_alf=0, assert pgm_sent_start_flag for exactly that cycle and go to WAIT_DONE; with in_rd_alf=1 it SHALL hold START with the flag low.
REQ-026 SHALL, in WAIT_DONE on rd2sched_pkt_done, increment sent_cnt (saturating at 0xFFFFFFFF), then choose the next state:
- FINISH if REPEAT!=0 and the new sent_cnt==REPEAT.
- FINISH if enable=0 or bypass=1.
- START if INTERVAL=0.
- GAP otherwise.
REQ-027 SHALL keep GAP for exactly INTERVAL cycles then go to START; enable=0 or bypass=1 during GAP SHALL go to FINISH.
REQ-028 SHALL, in FINISH, assert pgm_sent_finish_flag for one cycle, clear CTRL.enable, and go to IDLE.
REQ-029 SHALL never abort a packet mid-send: disabling during WAIT_DONE takes effect only after rd2sched_pkt_done.
REQ-030 SHALL ignore rd2sched_pkt_done in any state other than WAIT_DONE.
REQ-031 SHALL clear sent_cnt when a config write changes CTRL.enable from 0 to 1.
REQ-032 SHALL give the FINISH auto-clear of enable priority over a same-cycle config write to that bit.
REQ-033 SHALL have no effect on the FSM from a config write setting enable=1 while the FSM is not in IDLE.

Reset
REQ-034 SHALL, while rst_n=0, asynchronously force FSM=IDLE, CTRL=REPEAT=INTERVAL=0, sent_cnt=0, the gap counter to 0, and every output to 0 except cout_sched_ready, which follows cin_sched_ready.
REQ-035 SHALL, on reset mid-operation, drop any in-flight flit and issue no finish pulse; after release the block stays in IDLE until re-enabled.

Verification
REQ-036 SHALL cover reset: pulse rst_n low mid-packet -> all flags 0, cout_sched_data_wr=0, and STATUS reads 0.
REQ-037 SHALL cover a bounded run: write REPEAT=2, INTERVAL=3, CTRL=1, with done returned 5 cycles after each start -> two start pulses, the second exactly 4 cycles after the first done, then a finish pulse 1 cycle after the second done; STATUS=2 and CTRL reads 0.
REQ-038 SHALL cover backpressure: in_rd_alf=1 for 10 cycles in START -> no start pulse; a start pulse comes the first cycle after alf drops.
REQ-039 SHALL cover early disable: CTRL=0 written during WAIT_DONE -> no finish until done; finish 1 cycle after done; no further start.
REQ-040 SHALL cover the config path:
- A read of 0x04 -> header emerges 1 cycle later with opcode 011 and data=sent_cnt.
- A flit with ID 8'd62 -> forwarded bit-identical.
- A write with mask 0x0000FFFF -> changes only the low 16 bits.
REQ-041 SHALL cover bypass: CTRL=3'b011 -> pgm_bypass_flag=1 and no start pulse.
